// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus
// iterative shift-add multiply and restoring divide with a start/busy/done handshake.
module alu_multicycle #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] out,
  output logic [N-1:0] out_hi,
  output logic         busy,
  output logic         done,
  output logic         flag_zero,
  output logic         flag_carry,
  output logic         flag_neg,
  output logic         flag_ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [3:0] M_ADD = 4'd0;
  localparam logic [3:0] M_ADC = 4'd1;
  localparam logic [3:0] M_SUB = 4'd2;
  localparam logic [3:0] M_SBB = 4'd3;
  localparam logic [3:0] M_INC = 4'd4;
  localparam logic [3:0] M_DEC = 4'd5;
  localparam logic [3:0] M_AND = 4'd6;
  localparam logic [3:0] M_OR  = 4'd7;
  localparam logic [3:0] M_XOR = 4'd8;
  localparam logic [3:0] M_NOT = 4'd9;
  localparam logic [3:0] M_SHL = 4'd10;
  localparam logic [3:0] M_SHR = 4'd11;
  localparam logic [3:0] M_ROL = 4'd12;
  localparam logic [3:0] M_ROR = 4'd13;
  localparam logic [3:0] M_MUL = 4'd14;
  localparam logic [3:0] M_DIV = 4'd15;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  opr;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;
  logic          is_div;

  logic [N:0]    sum;
  logic [N-1:0]  r;
  logic [N-1:0]  rhi;
  logic          rc;
  logic          rv;
  logic          a_s;
  logic          b_s;
  logic          iter;

  always_comb begin
    sum = '0;
    r   = '0;
    rhi = '0;
    rc  = flag_carry;
    rv  = 1'b0;
    a_s = in_a[N-1];
    b_s = 1'b0;
    unique case (mode)
      M_ADD: begin
        sum = {1'b0, in_a} + {1'b0, in_b};
        b_s = in_b[N-1];
      end
      M_ADC: begin
        sum = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, flag_carry};
        b_s = in_b[N-1];
      end
      M_SUB: begin
        sum = {1'b0, in_a} - {1'b0, in_b};
        b_s = ~in_b[N-1];
      end
      M_SBB: begin
        sum = {1'b0, in_a} - {1'b0, in_b} - {{N{1'b0}}, flag_carry};
        b_s = ~in_b[N-1];
      end
      M_INC: sum = {1'b0, in_a} + {{N{1'b0}}, 1'b1};
      M_DEC: begin
        sum = {1'b0, in_a} - {{N{1'b0}}, 1'b1};
        b_s = 1'b1;
      end
      M_AND: r = in_a & in_b;
      M_OR:  r = in_a | in_b;
      M_XOR: r = in_a ^ in_b;
      M_NOT: r = ~in_a;
      M_SHL: begin
        r  = {in_a[N-2:0], 1'b0};
        rc = in_a[N-1];
      end
      M_SHR: begin
        r  = {1'b0, in_a[N-1:1]};
        rc = in_a[0];
      end
      M_ROL: begin
        r  = {in_a[N-2:0], in_a[N-1]};
        rc = in_a[N-1];
      end
      M_ROR: begin
        r  = {in_a[0], in_a[N-1:1]};
        rc = in_a[0];
      end
      M_DIV: begin
        r   = '1;
        rhi = in_a;
        rc  = 1'b1;
      end
      default: ;
    endcase
    // Arithmetic modes: overflow when effective operand signs agree but result sign differs
    if (mode <= M_DEC) begin
      r  = sum[N-1:0];
      rc = sum[N];
      rv = (a_s == b_s) && (sum[N-1] != a_s);
    end
  end

  logic [N:0]   madd;
  logic [N+1:0] dsub;
  logic [N-1:0] nhi;
  logic [N-1:0] nlo;

  always_comb begin
    madd = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opr} : '0);
    dsub = {1'b0, acc_hi, acc_lo[N-1]} - {2'b00, opr};
    if (is_div) begin
      if (!dsub[N+1]) begin
        nhi = dsub[N-1:0];
        nlo = {acc_lo[N-2:0], 1'b1};
      end else begin
        nhi = {acc_hi[N-2:0], acc_lo[N-1]};
        nlo = {acc_lo[N-2:0], 1'b0};
      end
    end else begin
      nhi = madd[N:1];
      nlo = {madd[0], acc_lo[N-1:1]};
    end
  end

  assign iter = (mode == M_MUL) || ((mode == M_DIV) && (in_b != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      opr        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      is_div     <= 1'b0;
      out        <= '0;
      out_hi     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && iter) begin
            state  <= EXEC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= (mode == M_DIV);
            opr    <= (mode == M_DIV) ? in_b : in_a;
            acc_hi <= '0;
            acc_lo <= (mode == M_DIV) ? in_a : in_b;
          end else if (start) begin
            out        <= r;
            out_hi     <= rhi;
            flag_carry <= rc;
            flag_ovf   <= rv;
            flag_zero  <= (r == '0);
            flag_neg   <= r[N-1];
            done       <= 1'b1;
          end
        end
        EXEC: begin
          acc_hi <= nhi;
          acc_lo <= nlo;
          if (cnt == CW'(N-1)) begin
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            out        <= nlo;
            out_hi     <= nhi;
            flag_carry <= is_div ? 1'b0 : (nhi != '0);
            flag_ovf   <= 1'b0;
            flag_zero  <= (nlo == '0);
            flag_neg   <= nlo[N-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (N=8): directed table, handshake corner
// cases and randomized ops against an integer reference model.
module tb_alu_multicycle;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] mode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] out;
  logic [7:0] out_hi;
  logic       busy;
  logic       done;
  logic       flag_zero;
  logic       flag_carry;
  logic       flag_neg;
  logic       flag_ovf;

  int errors = 0;
  int checks = 0;
  int mc = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.N(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .in_a(in_a),
    .in_b(in_b),
    .out(out),
    .out_hi(out_hi),
    .busy(busy),
    .done(done),
    .flag_zero(flag_zero),
    .flag_carry(flag_carry),
    .flag_neg(flag_neg),
    .flag_ovf(flag_ovf)
  );

  typedef struct {
    logic [3:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       ng;
    logic       v;
    int         lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model(input int m, input int a, input int b,
                       output int o, output int hi, output int c,
                       output int v, output int lat);
    int t;
    int s;
    int sa;
    int sb;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    t = 0;
    s = 0;
    hi = 0;
    v = 0;
    c = mc;
    lat = 0;
    o = 0;
    case (m)
      0: begin t = a + b;      s = sa + sb;      end
      1: begin t = a + b + mc; s = sa + sb + mc; end
      2: begin t = a - b;      s = sa - sb;      end
      3: begin t = a - b - mc; s = sa - sb - mc; end
      4: begin t = a + 1;      s = sa + 1;       end
      5: begin t = a - 1;      s = sa - 1;       end
      6: o = a & b;
      7: o = a | b;
      8: o = a ^ b;
      9: o = (~a) & 255;
      10: begin o = (a * 2) & 255; c = a / 128; end
      11: begin o = a / 2; c = a % 2; end
      12: begin o = ((a * 2) & 255) | (a / 128); c = a / 128; end
      13: begin o = (a / 2) | ((a % 2) * 128); c = a % 2; end
      14: begin
        o = (a * b) % 256;
        hi = (a * b) / 256;
        c = (hi != 0);
        lat = 8;
      end
      default: begin
        if (b == 0) begin
          o = 255; hi = a; c = 1;
        end else begin
          o = a / b; hi = a % b; c = 0; lat = 8;
        end
      end
    endcase
    if (m <= 5) begin
      o = t & 255;
      c = (t < 0 || t > 255);
      v = (s > 127 || s < -128);
    end
    mc = c;
  endtask

  task automatic run_op(input logic [3:0] m, input logic [7:0] a,
                        input logic [7:0] b, output int lat);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic chk_res(input string tag, input int o, input int hi,
                         input int c, input int v, input int lat,
                         input int glat);
    chk({tag, " out"}, out, o);
    chk({tag, " out_hi"}, out_hi, hi);
    chk({tag, " carry"}, flag_carry, c);
    chk({tag, " ovf"}, flag_ovf, v);
    chk({tag, " zero"}, flag_zero, (o == 0));
    chk({tag, " neg"}, flag_neg, (o >= 128));
    chk({tag, " latency"}, glat, lat);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int o, hi, c, v, lat, glat, dones, done_at;
    int m, a, b;
    int save_o, save_hi;
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, 0};
    vecs[1]  = '{4'd0,  8'h80, 8'h80, 8'h00, 8'h00, 1, 1, 0, 1, 0};
    vecs[2]  = '{4'd1,  8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 0};
    vecs[3]  = '{4'd2,  8'h10, 8'h20, 8'hF0, 8'h00, 1, 0, 1, 0, 0};
    vecs[4]  = '{4'd6,  8'h0F, 8'hF0, 8'h00, 8'h00, 1, 1, 0, 0, 0};
    vecs[5]  = '{4'd14, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1, 0, 0, 0, 8};
    vecs[6]  = '{4'd15, 8'd200, 8'd7, 8'h1C, 8'h04, 0, 0, 0, 0, 8};
    vecs[7]  = '{4'd15, 8'h55, 8'h00, 8'hFF, 8'h55, 1, 0, 1, 0, 0};
    vecs[8]  = '{4'd3,  8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 1, 0, 0};
    vecs[9]  = '{4'd4,  8'h7F, 8'h00, 8'h80, 8'h00, 0, 0, 1, 1, 0};
    vecs[10] = '{4'd5,  8'h00, 8'h00, 8'hFF, 8'h00, 1, 0, 1, 0, 0};
    vecs[11] = '{4'd13, 8'h01, 8'h00, 8'h80, 8'h00, 1, 0, 1, 0, 0};
    vecs[12] = '{4'd11, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0};
    vecs[13] = '{4'd12, 8'h80, 8'h00, 8'h01, 8'h00, 1, 0, 0, 0, 0};
    vecs[14] = '{4'd10, 8'h40, 8'h00, 8'h80, 8'h00, 0, 0, 1, 0, 0};
    vecs[15] = '{4'd9,  8'h0F, 8'h00, 8'hF0, 8'h00, 0, 0, 1, 0, 0};
    vecs[16] = '{4'd7,  8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0};
    vecs[17] = '{4'd8,  8'hFF, 8'h0F, 8'hF0, 8'h00, 0, 0, 1, 0, 0};

    reset = 1'b1;
    start = 1'b0;
    mode = '0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out", out, 0);
    chk("reset out_hi", out_hi, 0);
    chk("reset flags", {flag_zero, flag_carry, flag_neg, flag_ovf}, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      model(vecs[i].m, vecs[i].a, vecs[i].b, o, hi, c, v, lat);
      run_op(vecs[i].m, vecs[i].a, vecs[i].b, glat);
      chk($sformatf("vec%0d out", i), out, vecs[i].o);
      chk($sformatf("vec%0d out_hi", i), out_hi, vecs[i].hi);
      chk($sformatf("vec%0d carry", i), flag_carry, vecs[i].c);
      chk($sformatf("vec%0d zero", i), flag_zero, vecs[i].z);
      chk($sformatf("vec%0d neg", i), flag_neg, vecs[i].ng);
      chk($sformatf("vec%0d ovf", i), flag_ovf, vecs[i].v);
      chk($sformatf("vec%0d latency", i), glat, vecs[i].lat);
    end

    // MUL with a stray start pulse while busy
    @(negedge clk);
    start = 1'b1;
    mode = 4'd14;
    in_a = 8'hFF;
    in_b = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mul busy after accept", busy, 1);
    dones = 0;
    done_at = -1;
    save_o = 0;
    save_hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = (i == 2);
      mode = 4'd0;
      in_a = 8'd1;
      in_b = 8'd2;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        done_at = i;
        save_o = out;
        save_hi = out_hi;
      end
    end
    start = 1'b0;
    chk("mul stray start dones", dones, 1);
    chk("mul stray start done edge", done_at, 7);
    chk("mul stray start out", save_o, 8'h01);
    chk("mul stray start out_hi", save_hi, 8'hFE);
    mc = 1;

    // Reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1;
    mode = 4'd14;
    in_a = 8'h12;
    in_b = 8'h34;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort out", out, 0);
    chk("abort out_hi", out_hi, 0);
    chk("abort flags", {flag_zero, flag_carry, flag_neg, flag_ovf}, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    mc = 0;
    dones = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort no done", dones, 0);
    model(0, 1, 2, o, hi, c, v, lat);
    run_op(4'd0, 8'd1, 8'd2, glat);
    chk_res("post-reset add", o, hi, c, v, lat, glat);
    chk("post-reset add value", out, 3);

    // Randomized back-to-back ops
    for (int k = 0; k < 200; k++) begin
      m = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      model(m, a, b, o, hi, c, v, lat);
      run_op(m[3:0], a[7:0], b[7:0], glat);
      chk_res($sformatf("rand%0d m%0d", k, m), o, hi, c, v, lat, glat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
